// File: rtl/lsu_pkg.sv
// Shared types and the alignment check for the load/store read-modify-write unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } lsu_state_e;

  // Flags an illegal size code (2'b11) as well as a true misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Request/response handshake plus word-memory bus of the load/store unit.
interface lsu_rmw_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane extraction/extension and sub-word merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{ln, 3'b000} +: 8];
    h = word[{ln[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = old;
    case (sz)
      SZ_BYTE: r[{ln, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: r[{ln[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign load_data = extract(rd_word, size, lane, is_unsigned);
  assign merged    = merge(rd_word, wdata, size, lane);

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator: byte/half/word requests mapped onto a word memory,
// sub-word stores done as read-modify-write.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_rmw_if.slave   bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_rmw supports DATA_WIDTH == 32 only");
  end

  lsu_state_e               state_reg, state_next;
  logic                     we_reg, unsigned_reg;
  logic [1:0]               size_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [31:0]              wdata_reg, merge_reg;
  logic                     resp_valid_reg, resp_valid_next;
  logic                     resp_err_reg, resp_err_next;
  logic [31:0]              resp_rdata_reg, resp_rdata_next;
  logic                     mem_we_c;
  logic [ADDRESS_WIDTH-1:0] mem_addr_c;
  logic [31:0]              mem_wdata_c;
  logic [31:0]              load_data, merged;
  logic                     accept, acc_err;
  logic [ADDRESS_WIDTH-1:0] word_addr;

  assign bus.req_ready = (state_reg == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign acc_err       = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign word_addr     = {addr_reg[ADDRESS_WIDTH-1:2], 2'b00};

  lsu_lane_align u_align (
    .rd_word    (bus.mem_rdata),
    .wdata      (wdata_reg),
    .size       (size_reg),
    .lane       (addr_reg[1:0]),
    .is_unsigned(unsigned_reg),
    .load_data  (load_data),
    .merged     (merged)
  );

  always_comb begin
    state_next      = state_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = 32'd0;
    mem_we_c        = 1'b0;
    mem_addr_c      = '0;
    mem_wdata_c     = 32'd0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (acc_err) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else if (!bus.req_we || bus.req_size != SZ_WORD) begin
            state_next = RD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: begin
        mem_addr_c = word_addr;
        if (we_reg) begin
          state_next = WR;
        end else begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
          resp_rdata_next = load_data;
        end
      end
      WR: begin
        mem_addr_c      = word_addr;
        mem_we_c        = !rst;
        mem_wdata_c     = (size_reg == SZ_WORD) ? wdata_reg : merge_reg;
        state_next      = IDLE;
        resp_valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= 2'b00;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      merge_reg      <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept) begin
        we_reg       <= bus.req_we;
        unsigned_reg <= bus.req_unsigned;
        size_reg     <= bus.req_size;
        addr_reg     <= bus.req_addr;
        wdata_reg    <= bus.req_wdata;
      end
      // Merge is resolved while the old word is on the bus, so WR only replays it.
      if (state_reg == RD && we_reg) merge_reg <= merged;
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed scenarios then random traffic vs a
// byte-level reference memory.
module tb_lsu_rmw;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   wr_count = 0;
  int   wr_expected = 0;
  logic [31:0] last_wdata = 32'd0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_val = 32'd0;
  exp_t        exp_q[$];

  lsu_rmw_if bus ();

  lsu_rmw #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard on every response and tracks memory writes.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_count++;
      last_wdata = bus.mem_wdata;
    end
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  // Reference: plain byte-lane arithmetic on a word array, applied in acceptance order.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          idx, sh, nbytes;
    logic [31:0] word, field, mask;
    idx = int'(addr[9:2]);
    e.err = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    e.rdata = 32'd0;
    e.acc_cyc = 0;
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh     = 8 * int'(addr % 4);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
    word   = ref_mem[idx];
    if (we) begin
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      wr_expected++;
      e.lat = (nbytes == 4) ? 2 : 3;
    end else begin
      field = (word >> sh) & mask;
      if (!uns && nbytes == 1 && field >= 32'h80) field = field + 32'hFFFF_FF00;
      if (!uns && nbytes == 2 && field >= 32'h8000) field = field + 32'hFFFF_0000;
      e.rdata = field;
      e.lat = 2;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit use_model,
                       output int acc);
    int tries = 0;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    while (!bus.req_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (use_model) begin
      e = model(we, sz, uns, addr, wd);
      e.acc_cyc = acc;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_size = 2'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    poke_en = 1'b1;
    poke_idx = addr[9:2];
    poke_val = val;
    ref_mem[addr[9:2]] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  initial begin
    int a1, a2, wr0, bad;
    logic [31:0] ad;
    logic [1:0]  sz;
    bus.req_unsigned = 1'b0;
    idle();
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // Byte store read-modify-write
    poke(32'h100, 32'h1122_3344);
    wr0 = wr_count;
    issue(1, 2'd0, 0, 32'h102, 32'h0000_00AB, 1, a1);
    drain();
    check("sb_wdata", last_wdata, 32'h11AB_3344);
    check("sb_write_cycles", wr_count - wr0, 32'd1);

    // Signed/unsigned loads
    poke(32'h200, 32'h80FF_7F01);
    issue(0, 2'd0, 0, 32'h202, 32'd0, 1, a1);
    drain();
    issue(0, 2'd0, 1, 32'h203, 32'd0, 1, a1);
    drain();
    issue(0, 2'd1, 0, 32'h200, 32'd0, 1, a1);
    drain();
    issue(0, 2'd1, 1, 32'h202, 32'd0, 1, a1);
    drain();

    // Word store, load issued in its response cycle
    wr0 = wr_count;
    issue(1, 2'd2, 0, 32'h300, 32'hDEAD_BEEF, 1, a1);
    issue(0, 2'd2, 0, 32'h300, 32'd0, 1, a2);
    drain();
    check("sw_lw_backtoback", a2 - a1, 32'd2);
    check("sw_write_cycles", wr_count - wr0, 32'd1);

    // Misaligned / illegal
    wr0 = wr_count;
    issue(1, 2'd1, 0, 32'h101, 32'h5555_5555, 1, a1);
    issue(0, 2'd2, 0, 32'h102, 32'd0, 1, a1);
    issue(1, 2'd3, 0, 32'h104, 32'h6666_6666, 1, a1);
    drain();
    check("err_no_write", wr_count - wr0, 32'd0);

    // Reset during the WR cycle of a byte store
    wr0 = wr_count;
    issue(1, 2'd0, 0, 32'h140, 32'h0000_00EE, 0, a1);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_wr_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_idle", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rst_wr_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("rst_wr_word", mem[8'h50], ref_mem[8'h50]);
    check("rst_wr_no_write", wr_count - wr0, 32'd0);

    // Request held through a sub-word store
    issue(1, 2'd0, 0, 32'h181, 32'h0000_0077, 1, a1);
    issue(1, 2'd1, 0, 32'h186, 32'h0000_9988, 1, a2);
    drain();
    check("stall_accept", a2 - a1, 32'd3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), ad, $urandom, 1, a1);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    drain();

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_mem_mismatches", bad, 32'd0);
    check("total_writes", wr_count, wr_expected);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store initiator between the CPU execute/memory stage and the word-addressed data memory.
- The data memory has one write enable, whole-word writes, and a combinational read.
- This block converts byte, halfword and word loads/stores into word accesses:
  - sub-word stores use read-modify-write;
  - loads use lane extraction with sign or zero extension.
- It uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- ADDRESS_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, data width. Only 32 is supported; an elaboration assertion rejects any other value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDRESS_WIDTH  byte address.
- req_wdata  input  32  store data; the low byte or half is used for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; misaligned or illegal size.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDRESS_WIDTH  word address; bits [1:0] always 0.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- States: IDLE, RD, WR.
- Reset:
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - All request latches = 0.
- req_ready = (state==IDLE) && !rst. A request is accepted when req_valid && req_ready. All req_* fields are latched on acceptance.
- Error check at acceptance:
  - size 11 is an error;
  - half with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error.
- On error: no memory access, state stays IDLE, and the next cycle carries resp_valid=1, resp_err=1, resp_rdata=0.
- Transitions from IDLE on acceptance:
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD:
  - mem_addr = {latched addr[AW-1:2], 2'b00}, mem_we=0.
  - For a load: extract the lane at the edge, set resp_valid=1 next cycle, go to IDLE.
  - For a store: capture mem_rdata into the merge register, go to WR.
- WR:
  - mem_addr as in RD.
  - mem_wdata = merged word for sub-word stores, or latched wdata for word stores.
  - mem_we = (state==WR) && !rst.
  - Go to IDLE; resp_valid=1, resp_err=0, resp_rdata=0 next cycle.
- Latency, counted from the acceptance cycle N:
  - load: response at N+2;
  - word store: response at N+2;
  - sub-word store: response at N+3;
  - error: response at N+1.
- Back-to-back operation: req_ready is high in the response cycle, so a new request may be accepted while resp_valid=1.
- Lanes (little-endian):
  - byte lane = addr[1:0], occupying bits [8*lane+7 : 8*lane];
  - half lane = addr[1], occupying bits [16*addr[1]+15 : 16*addr[1]].
  - Merge replaces only the addressed lane; other bytes keep the value read in RD.
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned=1. Word loads are passed through unchanged.
- Outside RD/WR: mem_we=0, mem_addr=0, mem_wdata=0.
- resp_valid is exactly one cycle wide. resp_err is cleared whenever resp_valid is 0.
- Reset mid-operation:
  - rst asserted during RD or WR forces state=IDLE at the next edge.
  - No write occurs in the reset cycle, because mem_we is gated.
  - No response is produced for the aborted request.
- Handshake: req_valid held while req_ready=0 is not accepted. Req_* inputs are ignored outside acceptance cycles.

Decomposition:
- Package lsu_pkg contains:
  - enum lsu_size_e {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10};
  - enum lsu_state_e {IDLE, RD, WR};
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align (purely combinational), with two functions:
  - extract plus extend (rdata, size, lane, unsigned → 32b);
  - merge (old word, wdata, size, lane → 32b).
- The FSM and registers stay in lsu_rmw.

Test Plan:
- Byte store:
  - Stimulus: memory word 0x100 = 0x11223344; store byte 0xAB to 0x102.
  - Required: RD then WR; mem_wdata=0x11AB3344; mem_we high exactly 1 cycle; resp_valid at N+3.
- Signed/unsigned loads:
  - Stimulus: memory word 0x200 = 0x80FF7F01.
  - Required: lb 0x202 → 0xFFFFFFFF; lbu 0x203 → 0x00000080; lh 0x200 → 0x00007F01; lhu 0x202 → 0x000080FF; each response at N+2.
- Word store then load:
  - Stimulus: sw 0xDEADBEEF to 0x300 (response at N+2, single write cycle); lw 0x300 issued in the response cycle.
  - Required: the lw is accepted in the response cycle and returns 0xDEADBEEF.
- Misaligned and illegal accesses:
  - Stimulus: sh to 0x101; lw from 0x102; size 11.
  - Required: resp_err=1 at N+1; mem_we never asserted; memory unchanged.
- Reset mid read-modify-write:
  - Stimulus: byte store accepted; rst asserted in the WR cycle.
  - Required: mem_we=0 that cycle; state IDLE; no resp_valid; target word unchanged.
- Handshake stall:
  - Stimulus: req_valid held for 3 cycles during a sub-word store.
  - Required: exactly one acceptance per IDLE cycle; the second request is accepted in the response cycle.
